vlsu_addr_gen: RTL and testbench
================================

Name: vlsu_addr_gen

Overview:
Per-element address generator sitting directly upstream of the vector LSU's OBI master controller. Given a base address, stride, element width (vsew) and vector length (vl), it emits one word-aligned address, byte-enable and sub-word offset per vector element over a valid/ready handshake. The LSU consumes these to issue OBI transfers. Covers both unit-stride and strided loads and stores, and flags misaligned elements.

Parameters:
ADDR_W, 32, address and stride width in bits
VL_W, 5, width of the vector-length and element-index fields

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
start_i  input  1  single-cycle request to begin a vector access; ignored unless in IDLE
strided_i  input  1  1 selects stride_i; 0 selects unit stride (element size in bytes)
base_i  input  ADDR_W  base byte address (vector op0 scalar)
stride_i  input  ADDR_W  byte stride, two's complement (vector op1 scalar)
vl_i  input  VL_W  number of elements to generate
vsew_i  input  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved
elem_valid_o  output  1  element descriptor valid
elem_ready_i  input  1  LSU accepts the descriptor
elem_addr_o  output  ADDR_W  word-aligned address {cur[ADDR_W-1:2],2'b00}
elem_be_o  output  4  byte enables for this element within the word
elem_off_o  output  2  byte offset cur[1:0], used by the LSU for data lane shifting
elem_idx_o  output  VL_W  element index, 0..vl-1
elem_last_o  output  1  asserted with the final element
busy_o  output  1  high in GEN and DONE
done_o  output  1  one-cycle completion pulse
err_o  output  1  valid only with done_o; 1 = misaligned element or reserved vsew

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0. Internal address, index, latched vl, stride and sew cleared. Reset asserted mid-sequence aborts immediately. No done_o is produced for the aborted sequence.
- States: IDLE, GEN, DONE.
- IDLE: on start_i, latch base, vl, vsew, and the effective stride. Effective stride = stride_i if strided_i, else 1<<vsew_i. Set cur=base and idx=0.
  - vsew_i=11: go to DONE with err=1.
  - vl_i=0: go to DONE with err=0.
  - Otherwise: go to GEN.
- GEN, combinational per current element:
  - bytes = 1<<sew.
  - mis = (cur & (bytes-1)) != 0.
  - If mis: elem_valid_o=0; next state DONE with err=1. Elements already accepted stand.
  - Else: elem_valid_o=1.
    - elem_be_o = (((1<<bytes)-1) << cur[1:0]) truncated to 4 bits.
    - elem_last_o = (idx == vl-1).
    - elem_addr_o, elem_off_o and elem_idx_o follow cur and idx.
- Handshake:
  - Transfer occurs when elem_valid_o & elem_ready_i.
  - While valid and not ready, all elem_* outputs hold stable.
  - Ready may be high before valid. Valid never depends combinationally on ready.
  - Back-to-back transfers are allowed: one element per cycle when ready is held high.
- On transfer: cur <= cur + stride, modulo 2^ADDR_W (wraps silently); idx <= idx+1. If elem_last_o, next state DONE with err=0.
- DONE: done_o=1 and err_o set for exactly one cycle, then return to IDLE. busy_o drops in the IDLE cycle.
- Latency:
  - First elem_valid_o appears the cycle after the start_i cycle.
  - done_o appears the cycle after the last transfer.
  - For vl=0 or reserved vsew, done_o appears the cycle after start_i.
- start_i while busy_o=1: ignored; latched values are unchanged. start_i in the same cycle as DONE is also ignored.
- Input changes (base_i, vl_i, etc.) after start are ignored.
- Negative stride: handled by wrap-around addition.
- vl_i is taken as unsigned; the maximum of 2^VL_W-1 elements is supported.

Test Plan:
- Unit-stride 32b: base=0x1000, vl=4, vsew=10, ready=1. Required: addrs 0x1000, 0x1004, 0x1008, 0x100C; be=1111 on each; last on idx 3; done_o one cycle later with err=0.
- Unit-stride 8b: base=0x2001, vl=5, vsew=00. Required:
  - addrs 0x2000 x3, then 0x2004 x2.
  - be 0010, 0100, 1000, 0001, 0010.
  - off 1, 2, 3, 0, 1.
- Strided 16b with backpressure: base=0x3002, stride=-6, vl=3, vsew=01, ready toggled 0/1. Required:
  - addrs 0x3000 (be 1100), 0x2FFC (be 0000... no: cur=0x2FFC, be 0011), 0x2FF4 (cur=0x2FF6, be 1100).
  - Outputs stable during ready=0.
- Misaligned: vsew=10, strided, base=0x4000, stride=0x6, vl=4. Required: element 0 transfers; element 1 (cur=0x4006) is never valid; done_o with err_o=1.
- vl=0 and vsew=11 starts: done_o one cycle after start with err_o=0 and 1 respectively; elem_valid_o never asserted. A start_i pulse during GEN does not disturb the sequence.
- Reset mid-GEN after 2 of 4 elements: all outputs 0 immediately; no done_o; a fresh start then runs the full sequence from idx 0.

Source files
------------

// File: rtl/vlsu_addr_gen.sv
// Per-element address generator for the vector LSU: walks base + k*stride for vl
// elements and hands each word-aligned address, byte enables and lane offset to the OBI master.
module vlsu_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int VL_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              strided_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [1:0]        vsew_i,
  output logic              elem_valid_o,
  input  logic              elem_ready_i,
  output logic [ADDR_W-1:0] elem_addr_o,
  output logic [3:0]        elem_be_o,
  output logic [1:0]        elem_off_o,
  output logic [VL_W-1:0]   elem_idx_o,
  output logic              elem_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [VL_W-1:0] VL_ONE = VL_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_stride;
  logic [VL_W-1:0]   r_vl;
  logic [VL_W-1:0]   r_idx;
  logic [1:0]        r_sew;
  logic              r_err;

  logic [1:0] w_align_mask;
  logic [3:0] w_be_base;
  logic       w_mis;
  logic       w_valid;
  logic       w_last;
  logic       w_fire;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_align_mask = 2'b00;
    w_be_base    = 4'b0001;
    case (r_sew)
      2'b01: begin
        w_align_mask = 2'b01;
        w_be_base    = 4'b0011;
      end
      2'b10: begin
        w_align_mask = 2'b11;
        w_be_base    = 4'b1111;
      end
      default: begin
        w_align_mask = 2'b00;
        w_be_base    = 4'b0001;
      end
    endcase
  end

  // Aligned elements never straddle a word, so the 4-bit shift loses nothing.
  assign w_mis   = (r_cur[1:0] & w_align_mask) != 2'b00;
  assign w_valid = (r_state == S_GEN) && !w_mis;
  assign w_last  = (r_idx == (r_vl - VL_ONE));
  assign w_fire  = w_valid && elem_ready_i;

  assign elem_valid_o = w_valid;
  assign elem_addr_o  = w_valid ? {r_cur[ADDR_W-1:2], 2'b00} : '0;
  assign elem_be_o    = w_valid ? (w_be_base << r_cur[1:0]) : 4'b0000;
  assign elem_off_o   = w_valid ? r_cur[1:0] : 2'b00;
  assign elem_idx_o   = w_valid ? r_idx : '0;
  assign elem_last_o  = w_valid && w_last;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = (r_state == S_DONE) && r_err;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_stride <= '0;
      r_vl     <= '0;
      r_idx    <= '0;
      r_sew    <= 2'b00;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_cur    <= base_i;
            r_stride <= strided_i ? stride_i : (ADDR_W'(1) << vsew_i);
            r_vl     <= vl_i;
            r_idx    <= '0;
            r_sew    <= vsew_i;
            if (vsew_i == 2'b11) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (vl_i == '0) begin
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_GEN;
            end
          end
        end
        S_GEN: begin
          if (w_mis) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_fire) begin
            r_cur <= r_cur + r_stride;
            r_idx <= r_idx + VL_ONE;
            if (w_last) begin
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlsu_addr_gen.sv
// Directed bench for vlsu_addr_gen: inputs driven and outputs sampled on the falling edge,
// expected descriptors hand-computed per vector.
module tb_vlsu_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        strided_i;
  logic [31:0] base_i;
  logic [31:0] stride_i;
  logic [4:0]  vl_i;
  logic [1:0]  vsew_i;
  logic        elem_valid_o;
  logic        elem_ready_i;
  logic [31:0] elem_addr_o;
  logic [3:0]  elem_be_o;
  logic [1:0]  elem_off_o;
  logic [4:0]  elem_idx_o;
  logic        elem_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  vlsu_addr_gen #(.ADDR_W(32), .VL_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .strided_i    (strided_i),
    .base_i       (base_i),
    .stride_i     (stride_i),
    .vl_i         (vl_i),
    .vsew_i       (vsew_i),
    .elem_valid_o (elem_valid_o),
    .elem_ready_i (elem_ready_i),
    .elem_addr_o  (elem_addr_o),
    .elem_be_o    (elem_be_o),
    .elem_off_o   (elem_off_o),
    .elem_idx_o   (elem_idx_o),
    .elem_last_o  (elem_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic [1:0] off, input logic [4:0] idx, input logic last);
    check({tag, " valid"}, 32'(elem_valid_o), 32'd1);
    check({tag, " addr"},  elem_addr_o, addr);
    check({tag, " be"},    32'(elem_be_o), 32'(be));
    check({tag, " off"},   32'(elem_off_o), 32'(off));
    check({tag, " idx"},   32'(elem_idx_o), 32'(idx));
    check({tag, " last"},  32'(elem_last_o), 32'(last));
  endtask

  // Called at a falling edge with the element visible; stalls for `stall` cycles, then accepts it.
  task automatic elem(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic [1:0] off, input logic [4:0] idx, input logic last,
                      input int stall);
    chk_fields(tag, addr, be, off, idx, last);
    if (stall > 0) begin
      elem_ready_i = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk_fields({tag, " hold"}, addr, be, off, idx, last);
      end
    end
    elem_ready_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_done(input string tag, input logic err);
    check({tag, " done"},  32'(done_o), 32'd1);
    check({tag, " err"},   32'(err_o), 32'(err));
    check({tag, " valid"}, 32'(elem_valid_o), 32'd0);
    check({tag, " busy"},  32'(busy_o), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " done"},  32'(done_o), 32'd0);
    check({tag, " busy"},  32'(busy_o), 32'd0);
    check({tag, " valid"}, 32'(elem_valid_o), 32'd0);
  endtask

  task automatic start(input logic strided, input logic [31:0] base, input logic [31:0] stride,
                       input logic [4:0] vl, input logic [1:0] sew);
    strided_i = strided;
    base_i    = base;
    stride_i  = stride;
    vl_i      = vl;
    vsew_i    = sew;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    strided_i    = 1'b0;
    base_i       = '0;
    stride_i     = '0;
    vl_i         = '0;
    vsew_i       = '0;
    elem_ready_i = 1'b1;
    #2;
    check("rst valid", 32'(elem_valid_o), 32'd0);
    check("rst addr",  elem_addr_o, 32'd0);
    check("rst be",    32'(elem_be_o), 32'd0);
    check("rst busy",  32'(busy_o), 32'd0);
    check("rst done",  32'(done_o), 32'd0);
    check("rst err",   32'(err_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Unit-stride 32-bit, ready held high.
    start(1'b0, 32'h1000, 32'h0, 5'd4, 2'b10);
    elem("u32 e0", 32'h1000, 4'b1111, 2'd0, 5'd0, 1'b0, 0);
    elem("u32 e1", 32'h1004, 4'b1111, 2'd0, 5'd1, 1'b0, 0);
    elem("u32 e2", 32'h1008, 4'b1111, 2'd0, 5'd2, 1'b0, 0);
    elem("u32 e3", 32'h100C, 4'b1111, 2'd0, 5'd3, 1'b1, 0);
    chk_done("u32 end", 1'b0);
    @(negedge clk);
    chk_idle("u32 idle");

    // Unit-stride 8-bit; a start pulse mid-sequence must be ignored.
    start(1'b0, 32'h2001, 32'h0, 5'd5, 2'b00);
    elem("u8 e0", 32'h2000, 4'b0010, 2'd1, 5'd0, 1'b0, 0);
    elem("u8 e1", 32'h2000, 4'b0100, 2'd2, 5'd1, 1'b0, 0);
    start_i = 1'b1;
    base_i  = 32'h9000;
    vl_i    = 5'd2;
    elem("u8 e2", 32'h2000, 4'b1000, 2'd3, 5'd2, 1'b0, 0);
    start_i = 1'b0;
    elem("u8 e3", 32'h2004, 4'b0001, 2'd0, 5'd3, 1'b0, 0);
    elem("u8 e4", 32'h2004, 4'b0010, 2'd1, 5'd4, 1'b1, 0);
    chk_done("u8 end", 1'b0);
    // Start coinciding with DONE is ignored as well.
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk_idle("u8 idle");
    @(negedge clk);
    chk_idle("u8 idle2");

    // Strided 16-bit, negative stride, backpressure on every element.
    elem_ready_i = 1'b0;
    start(1'b1, 32'h3002, 32'hFFFF_FFFA, 5'd3, 2'b01);
    elem("s16 e0", 32'h3000, 4'b1100, 2'd2, 5'd0, 1'b0, 1);
    elem("s16 e1", 32'h2FFC, 4'b0011, 2'd0, 5'd1, 1'b0, 2);
    elem("s16 e2", 32'h2FF4, 4'b1100, 2'd2, 5'd2, 1'b1, 1);
    chk_done("s16 end", 1'b0);
    @(negedge clk);

    // Misaligned second element: element 0 goes, element 1 never becomes valid.
    start(1'b1, 32'h4000, 32'h6, 5'd4, 2'b10);
    elem("mis e0", 32'h4000, 4'b1111, 2'd0, 5'd0, 1'b0, 0);
    check("mis e1 valid", 32'(elem_valid_o), 32'd0);
    check("mis e1 done",  32'(done_o), 32'd0);
    check("mis e1 busy",  32'(busy_o), 32'd1);
    @(negedge clk);
    chk_done("mis end", 1'b1);
    @(negedge clk);
    chk_idle("mis idle");

    // vl=0 and reserved vsew finish immediately.
    start(1'b0, 32'h5000, 32'h0, 5'd0, 2'b10);
    chk_done("vl0", 1'b0);
    @(negedge clk);
    chk_idle("vl0 idle");
    start(1'b0, 32'h5000, 32'h0, 5'd3, 2'b11);
    chk_done("sew3", 1'b1);
    @(negedge clk);
    chk_idle("sew3 idle");

    // Reset mid-sequence after two accepted elements, then a clean rerun.
    start(1'b0, 32'h6000, 32'h0, 5'd4, 2'b10);
    elem("rst e0", 32'h6000, 4'b1111, 2'd0, 5'd0, 1'b0, 0);
    elem("rst e1", 32'h6004, 4'b1111, 2'd0, 5'd1, 1'b0, 0);
    reset = 1'b1;
    #1;
    check("abort valid", 32'(elem_valid_o), 32'd0);
    check("abort addr",  elem_addr_o, 32'd0);
    check("abort be",    32'(elem_be_o), 32'd0);
    check("abort busy",  32'(busy_o), 32'd0);
    check("abort done",  32'(done_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle("post abort");
    end
    start(1'b0, 32'h6000, 32'h0, 5'd4, 2'b10);
    elem("re e0", 32'h6000, 4'b1111, 2'd0, 5'd0, 1'b0, 0);
    elem("re e1", 32'h6004, 4'b1111, 2'd0, 5'd1, 1'b0, 0);
    elem("re e2", 32'h6008, 4'b1111, 2'd0, 5'd2, 1'b0, 0);
    elem("re e3", 32'h600C, 4'b1111, 2'd0, 5'd3, 1'b1, 0);
    chk_done("re end", 1'b0);
    @(negedge clk);
    chk_idle("re idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
